// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy wave scheduler: FSM states,
// sprite start-address table, LFSR seed/taps and the lowest-free-slot encoder.
package enemy_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_DRAIN,
        S_OVER
    } sched_state_t;

    // Sprite start addresses, entry 0 is the reset/default sprite.
    localparam logic [3:0][15:0] ENEMY_ADR_TABLE = {16'h0600, 16'h0400, 16'h0200, 16'h0000};

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8+x^6+x^5+x^4+1 on a left-shifting register: feedback from bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // Returns {found, index} of the lowest set bit.
    function automatic logic [3:0] lowest_set(input logic [7:0] v);
        logic [3:0] res;
        res = 4'b0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) res = {1'b1, 3'(i)};
        end
        return res;
    endfunction

    function automatic logic [15:0] adr_pick(input logic [7:0] lfsr);
        return ENEMY_ADR_TABLE[lfsr[1:0]];
    endfunction

endpackage

// File: rtl/enemy_scheduler_if.sv
// Scheduler <-> enemy slot bank bundle; master = scheduler, slave = slot bank.
// Pure wiring, no latency; no backpressure beyond the slot_busy status.
interface enemy_scheduler_if #(
    parameter int N_SLOTS      = 4,
    parameter int ADDRESSWIDTH = 12
);
    logic [N_SLOTS-1:0]                   slot_busy;
    logic [N_SLOTS-1:0]                   slot_hit;
    logic [N_SLOTS-1:0]                   slot_escaped;
    logic [N_SLOTS-1:0]                   spawn_pulse;
    logic [N_SLOTS-1:0][ADDRESSWIDTH-1:0] adr_start;

    modport master (
        input  slot_busy, slot_hit, slot_escaped,
        output spawn_pulse, adr_start
    );

    modport slave (
        output slot_busy, slot_hit, slot_escaped,
        input  spawn_pulse, adr_start
    );
endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR choosing enemy sprites; advances one state per step.
// Output is the current register, next value visible the cycle after step.
module lfsr8
    import enemy_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_step,
    output logic [7:0] o_q
);
    logic [7:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= LFSR_SEED;
        end else if (i_step) begin
            r_q <= {r_q[6:0], ^(r_q & LFSR_TAPS)};
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/enemy_scheduler.sv
// Wave scheduler for N enemy slots: paces spawns off spawn_tick, tallies kills, ends game.
// All outputs registered, spawn 1 cycle after qualifying tick/slot free; held while all slots busy.
module enemy_scheduler
    import enemy_pkg::*;
#(
    parameter int N_SLOTS      = 4,
    parameter int ADDRESSWIDTH = 12,
    parameter int WAVE_SIZE    = 8,
    parameter int BASE_DIV     = 6,
    parameter int MIN_DIV      = 2,
    parameter int SCORE_WIDTH  = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_en,
    input  logic                   i_spawn_tick,
    enemy_scheduler_if.master      slots,
    output logic [7:0]             o_wave,
    output logic [SCORE_WIDTH-1:0] o_score,
    output logic                   o_game_over
);
    localparam logic [ADDRESSWIDTH-1:0] ADR_RST = ADDRESSWIDTH'(ENEMY_ADR_TABLE[0]);

    sched_state_t                         r_state;
    logic [7:0]                           r_spawned_cnt;
    logic [7:0]                           r_div_cnt;
    logic [7:0]                           r_div_cur;
    logic [7:0]                           r_wave;
    logic [SCORE_WIDTH-1:0]               r_score;
    logic                                 r_game_over;
    logic [N_SLOTS-1:0]                   r_reserved;
    logic [N_SLOTS-1:0]                   r_busy_q;
    logic [N_SLOTS-1:0]                   r_spawn_pulse;
    logic [N_SLOTS-1:0][ADDRESSWIDTH-1:0] r_adr_start;

    logic [7:0]               w_lfsr_q;
    logic [N_SLOTS-1:0]       w_busy_fall;
    logic [N_SLOTS-1:0]       w_free;
    logic [3:0]               w_enc;
    logic                     w_escape;
    logic                     w_qual_tick;
    logic                     w_issue;
    logic [N_SLOTS-1:0]       w_set;
    logic [ADDRESSWIDTH-1:0]  w_adr_new;
    logic [7:0]               w_div_next;
    logic [3:0]               w_hit_cnt;
    logic [SCORE_WIDTH:0]     w_score_sum;
    logic [SCORE_WIDTH-1:0]   w_score_next;

    // A slot whose busy falls this cycle is already free for a pending issue.
    assign w_busy_fall = r_busy_q & ~slots.slot_busy;
    assign w_free      = ~slots.slot_busy & ~(r_reserved & ~w_busy_fall);
    assign w_enc       = lowest_set(8'(w_free));
    assign w_escape    = |slots.slot_escaped;
    assign w_adr_new   = ADDRESSWIDTH'(adr_pick(w_lfsr_q));

    // A qualifying tick issues straight from WAIT when a slot is free, so the
    // pulse lands one cycle after the tick; ISSUE only holds a blocked spawn.
    assign w_qual_tick = (r_state == S_WAIT) && (r_spawned_cnt != 8'(WAVE_SIZE)) &&
                         i_spawn_tick && (r_div_cnt == r_div_cur - 8'd1);
    assign w_issue     = i_en && !w_escape && w_enc[3] &&
                         ((r_state == S_ISSUE) || w_qual_tick);

    assign w_div_next  = (r_wave >= 8'(BASE_DIV - MIN_DIV)) ? 8'(MIN_DIV)
                                                             : 8'(BASE_DIV) - r_wave;

    always_comb begin
        w_set     = '0;
        w_hit_cnt = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (w_issue && (w_enc[2:0] == 3'(i))) w_set[i] = 1'b1;
            w_hit_cnt = w_hit_cnt + 4'(slots.slot_hit[i]);
        end
    end

    assign w_score_sum  = {1'b0, r_score} + (SCORE_WIDTH + 1)'(w_hit_cnt);
    assign w_score_next = w_score_sum[SCORE_WIDTH] ? '1 : w_score_sum[SCORE_WIDTH-1:0];

    lfsr8 u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_step (w_issue),
        .o_q    (w_lfsr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_spawned_cnt <= '0;
            r_div_cnt     <= '0;
            r_div_cur     <= 8'(BASE_DIV);
            r_wave        <= '0;
            r_score       <= '0;
            r_game_over   <= 1'b0;
            r_reserved    <= '0;
            r_busy_q      <= '0;
            r_spawn_pulse <= '0;
            for (int i = 0; i < N_SLOTS; i++) r_adr_start[i] <= ADR_RST;
        end else begin
            r_spawn_pulse <= w_set;
            r_busy_q      <= slots.slot_busy;
            if (r_state != S_OVER) begin
                r_score <= w_score_next;
                if (w_escape) begin
                    r_state     <= S_OVER;
                    r_game_over <= 1'b1;
                end else if (!i_en) begin
                    r_state       <= S_IDLE;
                    r_reserved    <= '0;
                    r_spawned_cnt <= '0;
                    r_div_cnt     <= '0;
                end else begin
                    r_reserved <= (r_reserved & ~w_busy_fall) | w_set;
                    for (int i = 0; i < N_SLOTS; i++) begin
                        if (w_set[i]) r_adr_start[i] <= w_adr_new;
                    end
                    if (w_issue) r_spawned_cnt <= r_spawned_cnt + 8'd1;
                    case (r_state)
                        S_IDLE: begin
                            r_state       <= S_WAIT;
                            r_spawned_cnt <= '0;
                            r_div_cnt     <= '0;
                            r_div_cur     <= w_div_next;
                        end
                        S_WAIT: begin
                            if (r_spawned_cnt == 8'(WAVE_SIZE)) begin
                                r_state <= S_DRAIN;
                            end else if (w_qual_tick) begin
                                r_div_cnt <= '0;
                                if (!w_enc[3]) r_state <= S_ISSUE;
                            end else if (i_spawn_tick) begin
                                r_div_cnt <= r_div_cnt + 8'd1;
                            end
                        end
                        S_ISSUE: begin
                            if (w_enc[3]) r_state <= S_WAIT;
                        end
                        S_DRAIN: begin
                            if ((slots.slot_busy == '0) && (r_reserved == '0)) begin
                                if (r_wave != 8'hFF) r_wave <= r_wave + 8'd1;
                                r_state <= S_IDLE;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign slots.spawn_pulse = r_spawn_pulse;
    assign slots.adr_start   = r_adr_start;
    assign o_wave            = r_wave;
    assign o_score           = r_score;
    assign o_game_over       = r_game_over;
endmodule
